// File: rtl/bel_cmul2n.sv
// Complex up-scaler: multiplies each component by 2^shift with saturation.
// Two-stage valid/ready pipeline, per-frame shift latch, sticky saturation flag and counter.
`timescale 1ns/1ps
module bel_cmul2n #(
  parameter int word_width  = 16,
  parameter int shift_width = 4,
  parameter int cnt_width   = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   sof_i,
  input  logic [shift_width-1:0] shift_i,
  input  logic [word_width-1:0]  a_re_i,
  input  logic [word_width-1:0]  a_im_i,
  input  logic                   valid_i,
  output logic                   ready_o,
  output logic [word_width-1:0]  x_re_o,
  output logic [word_width-1:0]  x_im_o,
  output logic                   sof_o,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic                   sat_o,
  input  logic                   sat_clr_i,
  output logic [cnt_width-1:0]   sat_cnt_o
);

  localparam int prod_width = word_width + (1 << shift_width);

  logic                   s1_valid_q, s1_sof_q;
  logic [word_width-1:0]  s1_re_q, s1_im_q;
  logic [shift_width-1:0] s1_shift_q, shift_q;
  logic                   s2_valid_q, s2_sof_q, s2_sat_q;
  logic [word_width-1:0]  s2_re_q, s2_im_q;
  logic                   sat_q;
  logic [cnt_width-1:0]   sat_cnt_q;

  logic                   s1_adv, s2_adv, in_xfer, out_xfer;
  logic [shift_width-1:0] eff_shift;
  logic [word_width-1:0]  x_re_d, x_im_d;
  logic                   sat_re, sat_im, s2_sat_d;

  // Shift, sign-extended into a product wide enough for any legal shift, then clamp.
  function automatic logic [word_width:0] sat_shift(input logic [word_width-1:0]  c,
                                                    input logic [shift_width-1:0] s);
    logic [prod_width-1:0]            p;
    logic [prod_width-word_width:0]   hi;
    p  = {{(prod_width-word_width){c[word_width-1]}}, c} << s;
    hi = p[prod_width-1:word_width-1];
    if (!p[prod_width-1] && (|hi))
      return {1'b1, 1'b0, {(word_width-1){1'b1}}};
    else if (p[prod_width-1] && !(&hi))
      return {1'b1, 1'b1, {(word_width-1){1'b0}}};
    else
      return {1'b0, p[word_width-1:0]};
  endfunction

  assign s2_adv    = !s2_valid_q || ready_i;
  assign s1_adv    = !s1_valid_q || s2_adv;
  assign ready_o   = s1_adv;
  assign in_xfer   = valid_i && s1_adv;
  assign out_xfer  = s2_valid_q && ready_i;
  assign eff_shift = sof_i ? shift_i : shift_q;

  always_comb begin
    {sat_re, x_re_d} = sat_shift(s1_re_q, s1_shift_q);
    {sat_im, x_im_d} = sat_shift(s1_im_q, s1_shift_q);
    s2_sat_d         = sat_re || sat_im;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      // NOTE: datapath registers are reset too, since the outputs must read zero after reset.
      shift_q    <= '0;
      s1_valid_q <= 1'b0;
      s1_sof_q   <= 1'b0;
      s1_re_q    <= '0;
      s1_im_q    <= '0;
      s1_shift_q <= '0;
      s2_valid_q <= 1'b0;
      s2_sof_q   <= 1'b0;
      s2_sat_q   <= 1'b0;
      s2_re_q    <= '0;
      s2_im_q    <= '0;
      sat_q      <= 1'b0;
      sat_cnt_q  <= '0;
    end else begin
      if (in_xfer && sof_i)
        shift_q <= shift_i;

      if (s1_adv) begin
        s1_valid_q <= valid_i;
        s1_sof_q   <= sof_i && valid_i;
        s1_re_q    <= a_re_i;
        s1_im_q    <= a_im_i;
        s1_shift_q <= eff_shift;
      end

      if (s2_adv) begin
        s2_valid_q <= s1_valid_q;
        s2_sof_q   <= s1_sof_q;
        s2_sat_q   <= s2_sat_d && s1_valid_q;
        s2_re_q    <= x_re_d;
        s2_im_q    <= x_im_d;
      end

      // A saturated transfer wins over a same-cycle clear.
      if (out_xfer && s2_sat_q) begin
        sat_q <= 1'b1;
        if (sat_clr_i)
          sat_cnt_q <= {{(cnt_width-1){1'b0}}, 1'b1};
        else if (sat_cnt_q != {cnt_width{1'b1}})
          sat_cnt_q <= sat_cnt_q + 1'b1;
      end else if (sat_clr_i) begin
        sat_q     <= 1'b0;
        sat_cnt_q <= '0;
      end
    end
  end

  assign x_re_o    = s2_re_q;
  assign x_im_o    = s2_im_q;
  assign sof_o     = s2_sof_q;
  assign valid_o   = s2_valid_q;
  assign sat_o     = sat_q;
  assign sat_cnt_o = sat_cnt_q;

endmodule

// File: tb/tb_bel_cmul2n.sv
// Bench for bel_cmul2n: directed scenarios plus random traffic checked by a
// queue-based arithmetic reference model watching both handshakes.
`timescale 1ns/1ps
module tb_bel_cmul2n;

  logic        clk = 1'b0;
  logic        rst_i, sof_i, valid_i, ready_i, sat_clr_i;
  logic [3:0]  shift_i;
  logic [15:0] a_re_i, a_im_i;
  logic        ready_o, sof_o, valid_o, sat_o;
  logic [15:0] x_re_o, x_im_o, sat_cnt_o;

  always #5 clk = ~clk;

  bel_cmul2n dut (
    .clk_i(clk), .rst_i(rst_i), .sof_i(sof_i), .shift_i(shift_i),
    .a_re_i(a_re_i), .a_im_i(a_im_i), .valid_i(valid_i), .ready_o(ready_o),
    .x_re_o(x_re_o), .x_im_o(x_im_o), .sof_o(sof_o), .valid_o(valid_o),
    .ready_i(ready_i), .sat_o(sat_o), .sat_clr_i(sat_clr_i), .sat_cnt_o(sat_cnt_o)
  );

  typedef struct {
    logic [15:0] re;
    logic [15:0] im;
    logic        sof;
    logic        sat;
  } exp_t;

  int          total = 0;
  int          bad   = 0;
  exp_t        q[$];
  exp_t        mon_e;
  logic        sat_m;
  logic [15:0] cnt_m;
  logic [3:0]  shift_m;
  bit          mon_en = 0;
  bit          prev_stall = 0;
  bit          exp_rdy;
  logic [15:0] prev_re, prev_im;
  logic        prev_sof;

  // Reference: value * 2^s as an integer, clamped to the 16-bit signed range.
  function automatic logic [16:0] ref_scale(input logic [15:0] c, input int s);
    longint v;
    v = longint'($signed(c)) * (longint'(1) << s);
    if (v > 32767)  return {1'b1, 16'h7fff};
    if (v < -32768) return {1'b1, 16'h8000};
    return {1'b0, 16'(v)};
  endfunction

  // Scoreboard: sampled mid-cycle, applies what the coming rising edge will do.
  always @(negedge clk) begin
    if (mon_en) begin
      total++;
      if (sat_o !== sat_m) begin
        bad++; $display("FAIL mon_sat_o got=%0b exp=%0b t=%0t", sat_o, sat_m, $time);
      end
      total++;
      if (sat_cnt_o !== cnt_m) begin
        bad++; $display("FAIL mon_sat_cnt got=%0d exp=%0d t=%0t", sat_cnt_o, cnt_m, $time);
      end
      exp_rdy = !(q.size() == 2 && !ready_i);
      total++;
      if (ready_o !== exp_rdy) begin
        bad++; $display("FAIL mon_ready_o got=%0b exp=%0b inflight=%0d t=%0t",
                        ready_o, exp_rdy, q.size(), $time);
      end
      if (prev_stall) begin
        total++;
        if (valid_o !== 1'b1 || x_re_o !== prev_re || x_im_o !== prev_im || sof_o !== prev_sof) begin
          bad++; $display("FAIL mon_stall_hold got=(%0b,%h,%h,%0b) exp=(1,%h,%h,%0b) t=%0t",
                          valid_o, x_re_o, x_im_o, sof_o, prev_re, prev_im, prev_sof, $time);
        end
      end
      if (rst_i) begin
        q.delete();
        sat_m = 1'b0; cnt_m = '0; shift_m = '0; prev_stall = 0;
      end else begin
        if (valid_o && ready_i) begin
          total++;
          if (q.size() == 0) begin
            bad++; $display("FAIL mon_extra_beat got=(%h,%h) exp=none t=%0t", x_re_o, x_im_o, $time);
          end else begin
            mon_e = q.pop_front();
            if (x_re_o !== mon_e.re || x_im_o !== mon_e.im || sof_o !== mon_e.sof) begin
              bad++; $display("FAIL mon_beat got=(%h,%h,sof=%0b) exp=(%h,%h,sof=%0b) t=%0t",
                              x_re_o, x_im_o, sof_o, mon_e.re, mon_e.im, mon_e.sof, $time);
            end
            if (mon_e.sat) begin
              sat_m = 1'b1;
              if (sat_clr_i)            cnt_m = 16'd1;
              else if (cnt_m != 16'hffff) cnt_m = cnt_m + 16'd1;
            end else if (sat_clr_i) begin
              sat_m = 1'b0; cnt_m = '0;
            end
          end
        end else if (sat_clr_i) begin
          sat_m = 1'b0; cnt_m = '0;
        end
        if (valid_i && ready_o) begin
          int          s;
          logic [16:0] r, i;
          s = sof_i ? int'(shift_i) : int'(shift_m);
          if (sof_i) shift_m = shift_i;
          r = ref_scale(a_re_i, s);
          i = ref_scale(a_im_i, s);
          q.push_back('{re: r[15:0], im: i[15:0], sof: sof_i, sat: r[16] | i[16]});
        end
        prev_stall = valid_o && !ready_i;
        prev_re = x_re_o; prev_im = x_im_o; prev_sof = sof_o;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drive(input logic v, input logic sof, input logic [3:0] sh,
                       input logic [15:0] re, input logic [15:0] im);
    valid_i = v; sof_i = sof; shift_i = sh; a_re_i = re; a_im_i = im;
  endtask

  task automatic drain(input string name);
    int n = 0;
    valid_i = 1'b0; sat_clr_i = 1'b0; ready_i = 1'b1;
    while (q.size() != 0 && n < 40) begin tick(); n++; end
    tick();
    total++;
    if (q.size() != 0) begin
      bad++; $display("FAIL %s_drain got=%0d_left exp=0", name, q.size());
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1; ready_i = 1'b0; sat_clr_i = 1'b0;
    drive(1'b0, 1'b0, 4'd0, 16'd0, 16'd0);
    repeat (3) tick();
    rst_i = 1'b0;
    total++;
    if (valid_o !== 1'b0 || sof_o !== 1'b0 || x_re_o !== 16'd0 || x_im_o !== 16'd0) begin
      bad++; $display("FAIL reset_outputs got=(%0b,%0b,%h,%h) exp=(0,0,0000,0000)",
                      valid_o, sof_o, x_re_o, x_im_o);
    end
    total++;
    if (sat_o !== 1'b0 || sat_cnt_o !== 16'd0) begin
      bad++; $display("FAIL reset_sat got=(%0b,%0d) exp=(0,0)", sat_o, sat_cnt_o);
    end
    total++;
    if (ready_o !== 1'b1) begin
      bad++; $display("FAIL reset_ready got=%0b exp=1", ready_o);
    end
    q.delete(); sat_m = 1'b0; cnt_m = '0; shift_m = '0;
    mon_en = 1;
  endtask

  task automatic test_basic();
    ready_i = 1'b1;
    drive(1'b1, 1'b1, 4'd3, 16'd100, -16'sd100);
    tick();
    valid_i = 1'b0;
    total++;
    if (valid_o !== 1'b0) begin
      bad++; $display("FAIL basic_latency_early got=%0b exp=0", valid_o);
    end
    tick();
    total++;
    if (valid_o !== 1'b1 || x_re_o !== 16'd800 || x_im_o !== -16'sd800 || sof_o !== 1'b1) begin
      bad++; $display("FAIL basic_beat got=(%0b,%0d,%0d,%0b) exp=(1,800,-800,1)",
                      valid_o, $signed(x_re_o), $signed(x_im_o), sof_o);
    end
    tick();
    total++;
    if (sat_o !== 1'b0) begin
      bad++; $display("FAIL basic_sat got=%0b exp=0", sat_o);
    end
  endtask

  task automatic test_sat();
    ready_i = 1'b1;
    drive(1'b1, 1'b1, 4'd1, 16'd20000, -16'sd20000);
    tick();
    drive(1'b1, 1'b0, 4'd9, 16'd5, 16'd5);
    tick();
    valid_i = 1'b0;
    total++;
    if (x_re_o !== 16'h7fff || x_im_o !== 16'h8000) begin
      bad++; $display("FAIL sat_clamp got=(%h,%h) exp=(7fff,8000)", x_re_o, x_im_o);
    end
    tick();
    total++;
    if (x_re_o !== 16'd10 || x_im_o !== 16'd10 || sat_o !== 1'b1 || sat_cnt_o !== 16'd1) begin
      bad++; $display("FAIL sat_follow got=(%0d,%0d,%0b,%0d) exp=(10,10,1,1)",
                      x_re_o, x_im_o, sat_o, sat_cnt_o);
    end
    tick();
    total++;
    if (sat_o !== 1'b1 || sat_cnt_o !== 16'd1) begin
      bad++; $display("FAIL sat_sticky got=(%0b,%0d) exp=(1,1)", sat_o, sat_cnt_o);
    end
  endtask

  task automatic test_back_to_back();
    int  cyc = 0;
    bit  acc;
    for (int i = 0; i < 8; i++) begin
      int tries = 0;
      drive(1'b1, i == 0, (i == 0) ? 4'd2 : 4'($urandom),
            16'($urandom_range(0, 1000)), 16'($urandom_range(0, 1000)));
      acc = 0;
      while (!acc && tries < 20) begin
        ready_i = (cyc % 3 == 0);
        cyc++; tries++;
        @(negedge clk) acc = ready_o;
        tick();
      end
      total++;
      if (!acc) begin
        bad++; $display("FAIL b2b_accept got=timeout exp=accept beat=%0d", i);
      end
    end
    valid_i = 1'b0;
    for (int n = 0; n < 40 && q.size() != 0; n++) begin
      ready_i = (cyc % 3 == 0); cyc++;
      tick();
    end
    drain("b2b");
  endtask

  task automatic test_frame_switch();
    ready_i = 1'b1;
    drive(1'b1, 1'b1, 4'd2, 16'd1, 16'd1);          tick();
    drive(1'b1, 1'b0, 4'd7, 16'd2, 16'd2);          tick();
    drive(1'b1, 1'b0, 4'd7, 16'd1000, -16'sd1000);  tick();
    drive(1'b1, 1'b1, 4'd0, 16'd1000, -16'sd1000);  tick();
    valid_i = 1'b0;
    total++;
    if (x_re_o !== 16'd4000 || x_im_o !== -16'sd4000 || sof_o !== 1'b0) begin
      bad++; $display("FAIL frame_last_a got=(%0d,%0d,%0b) exp=(4000,-4000,0)",
                      $signed(x_re_o), $signed(x_im_o), sof_o);
    end
    tick();
    total++;
    if (x_re_o !== 16'd1000 || x_im_o !== -16'sd1000 || sof_o !== 1'b1) begin
      bad++; $display("FAIL frame_first_b got=(%0d,%0d,%0b) exp=(1000,-1000,1)",
                      $signed(x_re_o), $signed(x_im_o), sof_o);
    end
    drain("frame");
  endtask

  task automatic test_sat_clr();
    ready_i = 1'b1;
    drive(1'b1, 1'b1, 4'd15, 16'd3, 16'd0);
    tick();
    valid_i = 1'b0;
    tick();
    sat_clr_i = 1'b1;
    tick();
    sat_clr_i = 1'b0;
    total++;
    if (sat_o !== 1'b1 || sat_cnt_o !== 16'd1) begin
      bad++; $display("FAIL satclr_with_xfer got=(%0b,%0d) exp=(1,1)", sat_o, sat_cnt_o);
    end
    sat_clr_i = 1'b1;
    tick();
    sat_clr_i = 1'b0;
    total++;
    if (sat_o !== 1'b0 || sat_cnt_o !== 16'd0) begin
      bad++; $display("FAIL satclr_alone got=(%0b,%0d) exp=(0,0)", sat_o, sat_cnt_o);
    end
  endtask

  task automatic test_edges();
    ready_i = 1'b1;
    drive(1'b1, 1'b1, 4'd0, 16'h8000, 16'd0);
    tick(); valid_i = 1'b0; tick();
    total++;
    if (x_re_o !== 16'h8000 || x_im_o !== 16'd0) begin
      bad++; $display("FAIL edge_minneg_s0 got=(%h,%h) exp=(8000,0000)", x_re_o, x_im_o);
    end
    drive(1'b1, 1'b1, 4'd15, 16'd0, 16'd0);
    tick(); valid_i = 1'b0; tick();
    total++;
    if (x_re_o !== 16'd0 || x_im_o !== 16'd0) begin
      bad++; $display("FAIL edge_zero_s15 got=(%h,%h) exp=(0000,0000)", x_re_o, x_im_o);
    end
    tick();
    total++;
    if (sat_o !== 1'b0) begin
      bad++; $display("FAIL edge_no_sat got=%0b exp=0", sat_o);
    end
  endtask

  function automatic logic [15:0] pick();
    case ($urandom_range(0, 5))
      0:       return 16'h0000;
      1:       return 16'h8000;
      2:       return 16'h7fff;
      3:       return 16'($urandom_range(0, 15)) - 16'd8;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0, 4'($urandom), pick(), pick());
      ready_i   = ($urandom_range(0, 3) != 0);
      sat_clr_i = ($urandom_range(0, 19) == 0);
      tick();
    end
    drain("random");
  endtask

  task automatic test_reset_mid();
    ready_i = 1'b1;
    drive(1'b1, 1'b1, 4'd5, 16'd20000, 16'd0);
    tick(); valid_i = 1'b0; tick(); tick();
    ready_i = 1'b0;
    drive(1'b1, 1'b1, 4'd5, 16'd300, 16'd1); tick();
    drive(1'b1, 1'b0, 4'd5, 16'd2, 16'd2);   tick();
    valid_i = 1'b0;
    total++;
    if (ready_o !== 1'b0 || valid_o !== 1'b1 || sat_o !== 1'b1) begin
      bad++; $display("FAIL rstmid_setup got=(rdy=%0b,vld=%0b,sat=%0b) exp=(0,1,1)",
                      ready_o, valid_o, sat_o);
    end
    rst_i = 1'b1; tick(); rst_i = 1'b0;
    total++;
    if (valid_o !== 1'b0 || x_re_o !== 16'd0 || x_im_o !== 16'd0 || sof_o !== 1'b0 ||
        sat_o !== 1'b0 || sat_cnt_o !== 16'd0 || ready_o !== 1'b1) begin
      bad++; $display("FAIL rstmid_flush got=(%0b,%h,%h,%0b,%0b,%0d,%0b) exp=(0,0000,0000,0,0,0,1)",
                      valid_o, x_re_o, x_im_o, sof_o, sat_o, sat_cnt_o, ready_o);
    end
    ready_i = 1'b1;
    drive(1'b1, 1'b0, 4'd9, 16'd7, -16'sd7);
    tick(); valid_i = 1'b0; tick();
    total++;
    if (valid_o !== 1'b1 || x_re_o !== 16'd7 || x_im_o !== -16'sd7) begin
      bad++; $display("FAIL rstmid_shift0 got=(%0b,%0d,%0d) exp=(1,7,-7)",
                      valid_o, $signed(x_re_o), $signed(x_im_o));
    end
    tick();
    total++;
    if (valid_o !== 1'b0) begin
      bad++; $display("FAIL rstmid_no_extra got=%0b exp=0", valid_o);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sat();
    test_back_to_back();
    test_frame_switch();
    test_sat_clr();
    test_edges();
    test_random();
    test_reset_mid();
    drain("final");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
